tqvp_vga_capture: RTL

TQVP_VGA_CAPTURE -- requirements
Module: tqvp_vga_capture

---
 rtl/tqvp_vga_capture_if.sv | 37 +++
 rtl/tqvp_vga_capture.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tqvp_vga_capture_if.sv
// rtl/tqvp_vga_capture_if.sv - pin and register-bus bundle for tqvp_vga_capture
//
// Purpose: groups the video pins (ui_in/uo_out) and the register bus so the
// capture block takes a single bundle port.
// Signals:
//   ui_in[7:0]          video in: [0] hsync, [1] vsync, [2] pixel
//   uo_out[7:0]         {6'b0, capture state}
//   address[5:0]        register byte address
//   data_in[31:0]       write data
//   data_write_n[1:0]   11 none, 00 8b, 01 16b, 10 32b
//   data_read_n[1:0]    11 none, else read
//   data_out[31:0]      read data, combinational from address
//   data_ready          always 1
//   user_interrupt      capture-done interrupt, level
// Modports: master drives the inputs of the block, slave is the block.

interface tqvp_vga_capture_if;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  modport master (
    output ui_in, address, data_in, data_write_n, data_read_n,
    input  uo_out, data_out, data_ready, user_interrupt
  );

  modport slave (
    input  ui_in, address, data_in, data_write_n, data_read_n,
    output uo_out, data_out, data_ready, user_interrupt
  );
endinterface

// File: rtl/tqvp_vga_capture.sv
// rtl/tqvp_vga_capture.sv - 1-bit VGA frame sampler into a COLS x ROWS bit buffer
//
// Purpose: measures hsync/vsync timing and, once armed, samples the pixel
// input on a programmable X/Y grid into a small bit buffer readable over the
// register bus.
// Ports:
//   clk     project clock
//   rst_n   asynchronous active-low reset
//   bus     tqvp_vga_capture_if.slave (video pins + register bus)

module tqvp_vga_capture #(
  parameter int COLS = 32,
  parameter int ROWS = 10
) (
  input logic               clk,
  input logic               rst_n,
  tqvp_vga_capture_if.slave bus
);

  localparam int COL_W  = $clog2(COLS + 1);
  localparam int CIDX_W = $clog2(COLS);
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0]  r_sync;
  logic [1:0]  r_sync_d;
  logic [10:0] r_x_cnt;
  logic [9:0]  r_y_cnt;
  logic [15:0] r_line_period;
  logic [9:0]  r_lines;
  logic [7:0]  r_frame_cnt;

  logic [10:0] r_x_start;
  logic [6:0]  r_x_step;
  logic [9:0]  r_y_start;
  logic [6:0]  r_y_step;
  logic [4:0]  r_ctrl;

  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic [11:0]      r_next_x;
  logic [10:0]      r_next_y;
  logic             r_short;
  logic             r_irq;

  logic [COLS-1:0] r_buf [ROWS];

  logic w_wr;
  logic w_wr32;
  logic w_ctrl_wr;
  logic w_irq_clr;
  logic w_hs_act;
  logic w_hs_act_d;
  logic w_vs_act;
  logic w_vs_act_d;
  logic w_hs_edge;
  logic w_vs_edge;
  logic [6:0] w_x_step_eff;
  logic [6:0] w_y_step_eff;
  logic w_row_hit;
  logic w_row_adv;
  logic w_px_hit;
  logic w_enter_done;
  logic w_start_cap;
  logic [ROW_W-1:0] w_rd_row;
  logic w_rd_row_ok;
  logic w_unused_ok;

  assign w_wr      = (bus.data_write_n != 2'b11);
  assign w_wr32    = (bus.data_write_n == 2'b10);
  assign w_ctrl_wr = w_wr32 && (bus.address == 6'h38);
  assign w_irq_clr = w_wr && (bus.address == 6'h3C);

  // Polarity bit set means the sync pulse is high; XNOR turns both
  // polarities into an active-high level whose rising edge is the event.
  assign w_hs_act   = r_sync[0]   ~^ r_ctrl[2];
  assign w_hs_act_d = r_sync_d[0] ~^ r_ctrl[2];
  assign w_vs_act   = r_sync[1]   ~^ r_ctrl[3];
  assign w_vs_act_d = r_sync_d[1] ~^ r_ctrl[3];
  assign w_hs_edge  = w_hs_act & ~w_hs_act_d;
  assign w_vs_edge  = w_vs_act & ~w_vs_act_d;

  assign w_x_step_eff = (r_x_step == 7'd0) ? 7'd1 : r_x_step;
  assign w_y_step_eff = (r_y_step == 7'd0) ? 7'd1 : r_y_step;

  // next_x/next_y carry one extra bit so a step past the counter range
  // simply never matches again instead of wrapping onto a low coordinate.
  assign w_row_hit = (r_state == S_CAPTURE) && ({1'b0, r_y_cnt} == r_next_y);
  assign w_row_adv = w_row_hit && w_hs_edge && !w_vs_edge;
  assign w_px_hit  = w_row_hit && (r_col < COL_W'(COLS)) &&
                     ({1'b0, r_x_cnt} == r_next_x);

  assign w_enter_done = (w_state_nxt == S_DONE) && (r_state != S_DONE);
  assign w_start_cap  = (r_state == S_ARMED) && (w_state_nxt == S_CAPTURE);

  assign w_rd_row    = bus.address[2 +: ROW_W];
  assign w_rd_row_ok = (bus.address[1:0] == 2'b00) &&
                       ({28'd0, bus.address[5:2]} < 32'(ROWS));

  assign w_unused_ok = &{1'b0, bus.data_read_n, bus.ui_in[7:3], bus.data_in};

  // Sync registering and timing counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync        <= 2'b00;
      r_sync_d      <= 2'b00;
      r_x_cnt       <= '0;
      r_y_cnt       <= '0;
      r_line_period <= '0;
      r_lines       <= '0;
      r_frame_cnt   <= '0;
    end else begin
      r_sync   <= bus.ui_in[1:0];
      r_sync_d <= r_sync;
      if (w_hs_edge) begin
        r_x_cnt       <= '0;
        r_line_period <= {5'd0, r_x_cnt} + 16'd1;
      end else if (r_x_cnt != 11'h7FF) begin
        r_x_cnt <= r_x_cnt + 11'd1;
      end
      if (w_vs_edge) begin
        r_y_cnt     <= '0;
        r_lines     <= r_y_cnt;
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end else if (w_hs_edge && (r_y_cnt != 10'h3FF)) begin
        r_y_cnt <= r_y_cnt + 10'd1;
      end
    end
  end

  // Configuration registers (32-bit writes only)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_start <= '0;
      r_x_step  <= 7'd32;
      r_y_start <= '0;
      r_y_step  <= 7'd77;
      r_ctrl    <= '0;
    end else if (w_wr32) begin
      case (bus.address)
        6'h30: begin
          r_x_start <= bus.data_in[10:0];
          r_x_step  <= bus.data_in[22:16];
        end
        6'h34: begin
          r_y_start <= bus.data_in[9:0];
          r_y_step  <= bus.data_in[22:16];
        end
        6'h38:   r_ctrl <= bus.data_in[4:0];
        default: ;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state; a CTRL write overrides any engine event
  always_comb begin
    w_state_nxt = r_state;
    if (w_ctrl_wr) begin
      w_state_nxt = bus.data_in[0] ? S_ARMED : S_IDLE;
    end else begin
      case (r_state)
        S_ARMED:   if (w_vs_edge) w_state_nxt = S_CAPTURE;
        S_CAPTURE: begin
          if (w_vs_edge)
            w_state_nxt = S_DONE;
          else if (w_row_adv && (r_row == ROW_W'(ROWS - 1)))
            w_state_nxt = S_DONE;
        end
        S_DONE:    if (r_ctrl[1]) w_state_nxt = S_ARMED;
        default:   ;
      endcase
    end
  end

  // FSM outputs and register read mux
  always_comb begin
    bus.uo_out         = {6'b0, r_state};
    bus.data_ready     = 1'b1;
    bus.user_interrupt = r_irq & r_ctrl[4];
    bus.data_out       = '0;
    case (bus.address)
      6'h28: bus.data_out = {16'd0, r_line_period};
      6'h2C: bus.data_out = {22'd0, r_lines};
      6'h30: bus.data_out = {9'd0, r_x_step, 5'd0, r_x_start};
      6'h34: bus.data_out = {9'd0, r_y_step, 6'd0, r_y_start};
      6'h38: bus.data_out = {27'd0, r_ctrl};
      6'h3C: bus.data_out = {16'd0, r_frame_cnt, 5'd0, r_short, r_state};
      default: if (w_rd_row_ok) bus.data_out = 32'(r_buf[w_rd_row]);
    endcase
  end

  // Capture engine: grid position, short-frame flag and interrupt flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row    <= '0;
      r_col    <= '0;
      r_next_x <= '0;
      r_next_y <= '0;
      r_short  <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_start_cap) begin
        r_row    <= '0;
        r_col    <= '0;
        r_next_x <= {1'b0, r_x_start};
        r_next_y <= {1'b0, r_y_start};
      end else if (w_row_adv) begin
        r_row    <= r_row + ROW_W'(1);
        r_next_y <= r_next_y + {4'd0, w_y_step_eff};
        r_col    <= '0;
        r_next_x <= {1'b0, r_x_start};
      end else if (w_px_hit) begin
        r_col    <= r_col + COL_W'(1);
        r_next_x <= r_next_x + {5'd0, w_x_step_eff};
      end

      if (w_ctrl_wr && bus.data_in[0])
        r_short <= 1'b0;
      else if ((r_state == S_CAPTURE) && (w_state_nxt == S_DONE))
        r_short <= w_vs_edge;

      // A new DONE entry beats a software clear in the same cycle
      if (w_enter_done)
        r_irq <= 1'b1;
      else if (w_irq_clr)
        r_irq <= 1'b0;
    end
  end

  // Capture buffer has no reset and no CPU write path
  always_ff @(posedge clk) begin
    if (w_px_hit) r_buf[r_row][r_col[CIDX_W-1:0]] <= bus.ui_in[2];
  end

endmodule
